// File: rtl/ysyx_25060166_ifu.sv
// ysyx_25060166_ifu -- instruction fetch unit for the RV32E core.
//
// Owns the PC and fetches one word at a time from instruction memory.
// Each fetched word is handed to the decoder over a valid/ready handshake.
// A redirect from execute/branch logic replaces the PC at any time.
// Any fetch that a redirect makes stale is thrown away.
// At most one memory request is outstanding, and there is no prefetch.
//
// Ports:
//   clk, rst         core clock; synchronous active-high reset
//   imem_req_*       fetch request (valid/ready) carrying the word address
//   imem_rsp_*       fetch response (valid only): data plus access-fault flag
//   redirect_*       single-cycle PC redirect pulse and its target
//   inst_valid/ready handshake towards the IDU
//   inst, inst_pc    instruction word and its PC
//   inst_fault       instruction carries a misaligned or access fault
//   fetch_cnt        number of instructions consumed by the IDU since reset

module ysyx_25060166_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             imem_rsp_err,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_fault,
    output logic [31:0]      fetch_cnt
);

    // A faulting fetch is replaced by a NOP (addi x0,x0,0).
    // The decoder therefore always sees a legal encoding.
    localparam logic [WIDTH-1:0] NOP_INST = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc, pc_n;
    logic             drop, drop_n;
    logic [WIDTH-1:0] inst_n, inst_pc_n;
    logic             inst_fault_n;
    logic [31:0]      fetch_cnt_n;
    logic             misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    // A misaligned PC never reaches memory.
    // The fault is synthesised locally instead.
    assign imem_req_valid = (state == REQ) && !rst && !misaligned;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);

    // State and datapath registers. Memory is reset together with this unit,
    // so clearing everything here also forgets any fetch that was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC[WIDTH-1:0];
            drop       <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drop       <= drop_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_fault <= inst_fault_n;
            fetch_cnt  <= fetch_cnt_n;
        end
    end

    // Next-state logic. A redirect always wins for the next PC.
    // 'drop' records that the outstanding response belongs to the old PC
    // and must be swallowed when it arrives.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drop_n       = drop;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_fault_n = inst_fault;
        fetch_cnt_n  = fetch_cnt;

        case (state)
            REQ: begin
                if (misaligned) begin
                    // A redirect overrides the fault.
                    // In that case fetching simply resumes at the new target.
                    if (!redirect_valid) begin
                        state_n      = HOLD;
                        inst_n       = NOP_INST;
                        inst_pc_n    = pc;
                        inst_fault_n = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_n = WAIT;
                    if (redirect_valid) begin
                        drop_n = 1'b1;
                    end
                end
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (imem_rsp_valid) begin
                        state_n = REQ;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        state_n = REQ;
                        drop_n  = 1'b0;
                    end else begin
                        state_n      = HOLD;
                        inst_n       = imem_rsp_err ? NOP_INST : imem_rsp_data;
                        inst_pc_n    = pc;
                        inst_fault_n = imem_rsp_err;
                    end
                end
            end

            HOLD: begin
                // A handshake in the same cycle as a redirect still counts
                // as a consumed instruction.
                if (inst_ready) begin
                    fetch_cnt_n = fetch_cnt + 32'd1;
                end
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = REQ;
                end else if (inst_ready) begin
                    pc_n    = pc + PC_STEP;
                    state_n = REQ;
                end
            end

            default: begin
                state_n = REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25060166_ifu.sv
// tb_ysyx_25060166_ifu -- directed bench for the instruction fetch unit.
// Memory responses are driven by hand, one step at a time.
// Every expected value is written out explicitly.

module tb_ysyx_25060166_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    ysyx_25060166_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, then settle 1 time unit past it.
    // New inputs are applied and outputs sampled at that point.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        checkOutput({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        checkOutput({tag, "_inst"}, inst, 32'd0);
        checkOutput({tag, "_inst_pc"}, inst_pc, 32'd0);
        checkOutput({tag, "_fault"}, {31'd0, inst_fault}, 32'd0);
        checkOutput({tag, "_cnt"}, fetch_cnt, 32'd0);
    endtask

    task automatic checkHold(input string tag, input logic [31:0] exp_inst,
                             input logic [31:0] exp_pc, input logic exp_fault);
        checkOutput({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        checkOutput({tag, "_inst"}, inst, exp_inst);
        checkOutput({tag, "_pc"}, inst_pc, exp_pc);
        checkOutput({tag, "_fault"}, {31'd0, inst_fault}, {31'd0, exp_fault});
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'd0;
        imem_rsp_err = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        inst_ready = 1'b0;
        #1;
        applyStimulus();
        applyStimulus();
        checkReset("t1_rst");

        // T1: three back-to-back fetches with memory always ready; mem[i]=i.
        rst = 1'b0;
        #1;
        checkOutput("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
        checkOutput("t1_req_addr0", imem_req_addr, 32'h8000_0000);
        imem_rsp_data = 32'd0;
        applyStimulus();
        checkOutput("t1_wait_req", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("t1_wait_ivalid", {31'd0, inst_valid}, 32'd0);
        applyStimulus();
        checkHold("t1_i0", 32'd0, 32'h8000_0000, 1'b0);
        inst_ready = 1'b1;
        applyStimulus();
        checkOutput("t1_cnt1", fetch_cnt, 32'd1);
        checkOutput("t1_req_addr1", imem_req_addr, 32'h8000_0004);
        imem_rsp_data = 32'd1;
        applyStimulus();
        applyStimulus();
        checkHold("t1_i1", 32'd1, 32'h8000_0004, 1'b0);
        applyStimulus();
        imem_rsp_data = 32'd2;
        applyStimulus();
        applyStimulus();
        checkHold("t1_i2", 32'd2, 32'h8000_0008, 1'b0);
        applyStimulus();
        checkOutput("t1_cnt3", fetch_cnt, 32'd3);
        checkOutput("t1_req_addr3", imem_req_addr, 32'h8000_000C);

        // T2: stall the IDU in HOLD for five cycles.
        inst_ready = 1'b0;
        imem_rsp_data = 32'd3;
        applyStimulus();
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            checkHold("t2_stall", 32'd3, 32'h8000_000C, 1'b0);
            checkOutput("t2_no_req", {31'd0, imem_req_valid}, 32'd0);
            checkOutput("t2_cnt", fetch_cnt, 32'd3);
            applyStimulus();
        end
        inst_ready = 1'b1;
        applyStimulus();
        checkOutput("t2_cnt4", fetch_cnt, 32'd4);

        // T3: a redirect while in WAIT must drop the in-flight response.
        inst_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        applyStimulus();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        applyStimulus();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        applyStimulus();
        checkOutput("t3_dropped", {31'd0, inst_valid}, 32'd0);
        checkOutput("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
        checkOutput("t3_req_addr", imem_req_addr, 32'h8000_0100);
        imem_rsp_data = 32'h0000_0040;
        applyStimulus();
        applyStimulus();
        checkHold("t3_deliver", 32'h0000_0040, 32'h8000_0100, 1'b0);
        inst_ready = 1'b1;
        applyStimulus();
        checkOutput("t3_cnt5", fetch_cnt, 32'd5);

        // T4: misaligned redirect.
        // The fetch to 0x104 accepted in the same cycle is dropped.
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        applyStimulus();
        redirect_valid = 1'b0;
        applyStimulus();
        checkOutput("t4_no_req", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("t4_not_yet", {31'd0, inst_valid}, 32'd0);
        applyStimulus();
        checkHold("t4_misalign", 32'h0000_0013, 32'h8000_0102, 1'b1);

        // T5 (squash): redirect in HOLD without inst_ready leaves the count alone.
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        imem_req_ready = 1'b0;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("t5_squash_cnt", fetch_cnt, 32'd5);
        checkOutput("t5_squash_addr", imem_req_addr, 32'h8000_0200);
        checkOutput("t5_squash_req", {31'd0, imem_req_valid}, 32'd1);
        applyStimulus();
        checkOutput("t5_stall_addr", imem_req_addr, 32'h8000_0200);
        imem_req_ready = 1'b1;

        // T4 (access fault): an error response becomes a faulting NOP.
        imem_rsp_err = 1'b1;
        imem_rsp_data = 32'h1234_5678;
        applyStimulus();
        applyStimulus();
        checkHold("t4_err", 32'h0000_0013, 32'h8000_0200, 1'b1);
        imem_rsp_err = 1'b0;

        // T5: redirect together with inst_ready counts as a consume.
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0300;
        inst_ready = 1'b1;
        applyStimulus();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        checkOutput("t5_both_cnt", fetch_cnt, 32'd6);
        checkOutput("t5_both_addr", imem_req_addr, 32'h8000_0300);

        // T6: reset in WAIT, then reset in HOLD.
        imem_rsp_data = 32'h0000_0055;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkReset("t6_rst_wait");
        rst = 1'b0;
        #1;
        checkOutput("t6_restart", imem_req_addr, 32'h8000_0000);
        checkOutput("t6_restart_v", {31'd0, imem_req_valid}, 32'd1);
        applyStimulus();
        applyStimulus();
        checkHold("t6_refetch", 32'h0000_0055, 32'h8000_0000, 1'b0);
        rst = 1'b1;
        applyStimulus();
        checkReset("t6_rst_hold");
        rst = 1'b0;

        // T6: consuming an instruction at 0xFFFF_FFFC wraps the PC to zero.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        applyStimulus();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_data = 32'h0000_0077;
        applyStimulus();
        applyStimulus();
        checkHold("t6_top", 32'h0000_0077, 32'hFFFF_FFFC, 1'b0);
        inst_ready = 1'b1;
        applyStimulus();
        checkOutput("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
        checkOutput("t6_wrap_cnt", fetch_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
